// File: rtl/seq_alu.sv
// Sequential RV32IM-style ALU: single-cycle base ops, XLEN-iteration multiply/divide.
// Define SEQ_ALU_MULDIV_EN to build the M-extension datapath; otherwise fn7_bit0 is ignored.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      fn3,
  input  logic            fn7_bit5,
  input  logic            fn7_bit0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic accept;
  logic m_req;
  logic last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  function automatic logic [XLEN-1:0] base_op(input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y,
                                              input logic [2:0]      f,
                                              input logic            alt);
    logic signed [XLEN-1:0] sx;
    logic signed [XLEN-1:0] sy;
    logic signed [XLEN-1:0] sra;
    logic [SHW-1:0]         sh;
    sx  = x;
    sy  = y;
    sh  = y[SHW-1:0];
    sra = sx >>> sh;
    case (f)
      3'd0:    base_op = alt ? (x - y) : (x + y);
      3'd1:    base_op = x << sh;
      3'd2:    base_op = {{(XLEN-1){1'b0}}, (sx < sy)};
      3'd3:    base_op = {{(XLEN-1){1'b0}}, (x < y)};
      3'd4:    base_op = x ^ y;
      3'd5:    base_op = alt ? sra : (x >> sh);
      3'd6:    base_op = x | y;
      default: base_op = x & y;
    endcase
  endfunction

`ifdef SEQ_ALU_MULDIV_EN
  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b_in;
  logic [2:0]        fn3_r;
  logic [XLEN-1:0]   a_r, mag_b, hi, lo;
  logic              b_zero_r, neg_q, neg_r;
  logic [SHW-1:0]    cnt;
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   it_hi, it_lo, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   m_result;

  assign m_req = fn7_bit0;
  assign last  = (cnt == SHW'(XLEN-1));

  // Work on magnitudes; the sign is reapplied once the last iteration completes.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (fn3[2]) begin
      sa = ~fn3[0] & a[XLEN-1];
      sb = ~fn3[0] & b[XLEN-1];
    end else begin
      sa = (fn3 == 3'd1 || fn3 == 3'd2) && a[XLEN-1];
      sb = (fn3 == 3'd1) && b[XLEN-1];
    end
  end

  assign mag_a    = sa ? -a : a;
  assign mag_b_in = sb ? -b : b;

  // hi:lo is the product accumulator for multiply and remainder:quotient for divide.
  assign mul_sum  = {1'b0, hi} + ({1'b0, mag_b} & {(XLEN+1){lo[0]}});
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_ge   = (div_sh >= {1'b0, mag_b});
  assign div_diff = div_sh[XLEN-1:0] - mag_b;
  assign it_hi    = fn3_r[2] ? (div_ge ? div_diff : div_sh[XLEN-1:0]) : mul_sum[XLEN:1];
  assign it_lo    = fn3_r[2] ? {lo[XLEN-2:0], div_ge} : {mul_sum[0], lo[XLEN-1:1]};

  assign prod = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
  assign quo  = b_zero_r ? '1  : (neg_q ? -it_lo : it_lo);
  assign rem  = b_zero_r ? a_r : (neg_r ? -it_hi : it_hi);

  always_comb begin
    case (fn3_r)
      3'd0:             m_result = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: m_result = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       m_result = quo;
      default:          m_result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && m_req) begin
      fn3_r    <= fn3;
      a_r      <= a;
      mag_b    <= mag_b_in;
      hi       <= '0;
      lo       <= mag_a;
      b_zero_r <= (b == '0);
      neg_q    <= sa ^ sb;
      neg_r    <= sa;
      cnt      <= '0;
    end else if (state == BUSY) begin
      hi  <= it_hi;
      lo  <= it_lo;
      cnt <= cnt + SHW'(1);
    end
  end
`else
  logic unused_fn7;

  assign m_req      = 1'b0;
  assign last       = 1'b0;
  assign unused_fn7 = fn7_bit0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = m_req ? BUSY : DONE;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result only changes on a base accept or on multiply/divide completion, so it holds in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (accept && !m_req) begin
      result <= base_op(a, b, fn3, fn7_bit5);
`ifdef SEQ_ALU_MULDIV_EN
    end else if (state == BUSY && last) begin
      result <= m_result;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32), randomized against an arithmetic reference model.
// Exercises the M-extension when compiled with SEQ_ALU_MULDIV_EN, otherwise the base-only build.
module tb_seq_alu;
  localparam int XLEN = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit HAS_M = 1'b1;
`else
  localparam bit HAS_M = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  fn3 = '0;
  logic        fn7_bit5 = 1'b0;
  logic        fn7_bit0 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  f;
    logic        b5;
    logic [31:0] want;
  } vec_t;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .fn3(fn3), .fn7_bit5(fn7_bit5), .fn7_bit0(fn7_bit0),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] f, input logic alt, input logic m);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    r  = '0;
    if (m) begin
      case (f)
        3'd0:    r = 64'(sx * sy);
        3'd1:    r = 64'(sx * sy) >> 32;
        3'd2:    r = 64'(sx * longint'(uy)) >> 32;
        3'd3:    r = (ux * uy) >> 32;
        3'd4:    r = (y == 0) ? 64'hFFFF_FFFF : 64'(sx / sy);
        3'd5:    r = (y == 0) ? 64'hFFFF_FFFF : ux / uy;
        3'd6:    r = (y == 0) ? ux : 64'(sx % sy);
        default: r = (y == 0) ? ux : ux % uy;
      endcase
    end else begin
      case (f)
        3'd0:    r = alt ? ux - uy : ux + uy;
        3'd1:    r = ux << y[4:0];
        3'd2:    r = 64'(sx < sy);
        3'd3:    r = 64'(ux < uy);
        3'd4:    r = ux ^ uy;
        3'd5:    r = alt ? 64'(sx >>> y[4:0]) : ux >> y[4:0];
        3'd6:    r = ux | uy;
        default: r = ux & uy;
      endcase
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE, scramble inputs after accept, return result and cycles to out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f,
                        input logic b5, input logic b0, input bit release_out,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    a = x; b = y; fn3 = f; fn7_bit5 = b5; fn7_bit0 = b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; fn3 = 3'($urandom_range(0, 7));
    fn7_bit5 = 1'($urandom_range(0, 1)); fn7_bit0 = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    in_valid = 1'b1; a = 32'd5; b = 32'd7; fn3 = 3'd0; fn7_bit5 = 1'b0; fn7_bit0 = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      bad++; $display("FAIL reset_priority: got out_valid=%b in_ready=%b result=%h want 0 1 00000000", out_valid, in_ready, result);
    end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_base_directed();
    vec_t v[7];
    logic [31:0] res;
    int lat;
    v[0] = '{32'd5,          32'd7,          3'd0, 1'b0, 32'd12};
    v[1] = '{32'd5,          32'd7,          3'd0, 1'b1, 32'hFFFF_FFFE};
    v[2] = '{32'h8000_0000,  32'h0000_0024,  3'd5, 1'b1, 32'hF800_0000};
    v[3] = '{32'd1,          32'hFFFF_FFFF,  3'd3, 1'b0, 32'd1};
    v[4] = '{32'd1,          32'hFFFF_FFFF,  3'd2, 1'b0, 32'd0};
    v[5] = '{32'h8000_0000,  32'h0000_0024,  3'd5, 1'b0, 32'h0800_0000};
    v[6] = '{32'd1,          32'hFFFF_FFE1,  3'd1, 1'b0, 32'd2};
    foreach (v[i]) begin
      run_op(v[i].x, v[i].y, v[i].f, v[i].b5, 1'b0, 1'b1, res, lat);
      total++; if (res !== v[i].want) begin bad++; $display("FAIL base_dir[%0d]: got %h want %h", i, res, v[i].want); end
      total++; if (lat !== 1) begin bad++; $display("FAIL base_dir_lat[%0d]: got %0d want 1", i, lat); end
    end
  endtask

`ifdef SEQ_ALU_MULDIV_EN
  task automatic test_m_directed();
    vec_t v[11];
    logic [31:0] res;
    int lat;
    v[0]  = '{32'hFFFF_FFFF, 32'd2,         3'd1, 1'b0, 32'hFFFF_FFFF};
    v[1]  = '{32'hFFFF_FFFF, 32'd2,         3'd3, 1'b0, 32'h0000_0001};
    v[2]  = '{32'hFFFF_FFFF, 32'd2,         3'd0, 1'b0, 32'hFFFF_FFFE};
    v[3]  = '{32'd10,        32'd0,         3'd4, 1'b0, 32'hFFFF_FFFF};
    v[4]  = '{32'd10,        32'd0,         3'd6, 1'b0, 32'd10};
    v[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 32'h8000_0000};
    v[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 32'h0000_0000};
    v[7]  = '{32'hFFFF_FFF9, 32'd2,         3'd4, 1'b0, 32'hFFFF_FFFD};
    v[8]  = '{32'hFFFF_FFF9, 32'd2,         3'd6, 1'b0, 32'hFFFF_FFFF};
    v[9]  = '{32'd10,        32'd0,         3'd5, 1'b0, 32'hFFFF_FFFF};
    v[10] = '{32'd10,        32'd0,         3'd7, 1'b0, 32'd10};
    foreach (v[i]) begin
      run_op(v[i].x, v[i].y, v[i].f, v[i].b5, 1'b1, 1'b1, res, lat);
      total++; if (res !== v[i].want) begin bad++; $display("FAIL m_dir[%0d]: got %h want %h", i, res, v[i].want); end
      total++; if (lat !== XLEN + 1) begin bad++; $display("FAIL m_dir_lat[%0d]: got %0d want %0d", i, lat, XLEN + 1); end
    end
  endtask
`else
  task automatic test_no_m();
    logic [31:0] res;
    int lat;
    run_op(32'd3, 32'd4, 3'd0, 1'b0, 1'b1, 1'b1, res, lat);
    total++; if (res !== 32'd7) begin bad++; $display("FAIL no_m_add: got %h want 00000007", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL no_m_lat: got %0d want 1", lat); end
  endtask
`endif

  task automatic test_random(input logic m, input int n);
    logic [31:0] x, y, res, want;
    logic [2:0]  f;
    logic        b5, eff;
    int          lat, want_lat;
    eff = m && HAS_M;
    want_lat = eff ? XLEN + 1 : 1;
    for (int i = 0; i < n; i++) begin
      x = pick(); y = pick(); f = 3'($urandom_range(0, 7)); b5 = 1'($urandom_range(0, 1));
      want = ref_op(x, y, f, b5, eff);
      run_op(x, y, f, b5, m, 1'b1, res, lat);
      total++;
      if (res !== want) begin
        bad++; $display("FAIL rand_m%0b[%0d]: a=%h b=%h fn3=%0d b5=%b got %h want %h", m, i, x, y, f, b5, res, want);
      end
      total++; if (lat !== want_lat) begin bad++; $display("FAIL rand_lat_m%0b[%0d]: got %0d want %0d", m, i, lat, want_lat); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] x, y, res, want;
    logic [2:0]  f;
    logic        b5;
    int          lat;
    x = pick(); y = pick(); f = 3'($urandom_range(0, 7)); b5 = 1'($urandom_range(0, 1));
    want = ref_op(x, y, f, b5, 1'b0);
    run_op(x, y, f, b5, 1'b0, 1'b0, res, lat);
    total++; if (res !== want) begin bad++; $display("FAIL hold_first: got %h want %h", res, want); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; fn3 = 3'($urandom_range(0, 7));
      fn7_bit0 = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== want) begin
        bad++; $display("FAIL hold[%0d]: got out_valid=%b in_ready=%b result=%h want 1 0 %h", i, out_valid, in_ready, result, want);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back(input logic m);
    logic [31:0] expq[$];
    logic [31:0] x, y, want;
    logic [2:0]  f;
    logic        b5, eff;
    int          cyc, issued, got, last_acc, gap;
    eff = m && HAS_M;
    gap = eff ? XLEN + 2 : 2;
    cyc = 0; issued = 0; got = 0; last_acc = -1;
    out_ready = 1'b1;
    while (got < 6 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL b2b_extra_m%0b: got result %h with nothing pending", m, result);
        end else begin
          want = expq.pop_front();
          if (result !== want) begin bad++; $display("FAIL b2b_result_m%0b[%0d]: got %h want %h", m, got, result, want); end
        end
        got++;
      end
      x = pick(); y = pick(); f = 3'($urandom_range(0, 7)); b5 = 1'($urandom_range(0, 1));
      a = x; b = y; fn3 = f; fn7_bit5 = b5; fn7_bit0 = m;
      in_valid = (issued < 6);
      if (in_ready && issued < 6) begin
        expq.push_back(ref_op(x, y, f, b5, eff));
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc !== gap) begin bad++; $display("FAIL b2b_gap_m%0b: got %0d want %0d", m, cyc - last_acc, gap); end
        end
        last_acc = cyc;
        issued++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL b2b_count_m%0b: got %0d want 6", m, got); end
  endtask

  task automatic test_reset_mid(input logic m);
    logic busy;
    int   seen;
    busy = m && HAS_M;
    seen = 0;
    @(negedge clk);
    a = pick(); b = pick(); fn3 = 3'($urandom_range(0, 7)); fn7_bit5 = 1'($urandom_range(0, 1));
    fn7_bit0 = m; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (out_valid !== !busy) begin bad++; $display("FAIL midrst_pre_m%0b: got out_valid=%b want %b", m, out_valid, !busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      bad++; $display("FAIL midrst_m%0b: got out_valid=%b in_ready=%b result=%h want 0 1 00000000", m, out_valid, in_ready, result);
    end
    out_ready = 1'b1;
    repeat (XLEN + 10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_stale_m%0b: got %0d result cycles want 0", m, seen); end
  endtask

  initial begin
    test_reset();
    test_base_directed();
    test_random(1'b0, 40);
    test_hold();
    test_back_to_back(1'b0);
    test_reset_mid(1'b0);
`ifdef SEQ_ALU_MULDIV_EN
    test_m_directed();
`else
    test_no_m();
`endif
    test_random(1'b1, 30);
    test_back_to_back(1'b1);
    test_reset_mid(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
